cdb_sched: RTL and testbench
============================

CDB_SCHED -- requirements
Module: cdb_sched

Interface
REQ-001 SHALL have parameter N_CH, default 4, number of execution channels (2..8).
REQ-002 SHALL have parameter DATA_W, default 32, CDB result width.
REQ-003 SHALL have parameter TAG_W, default 6, CDB tag width.
REQ-004 SHALL have parameter DEPTH, default 8, reservation window in cycles (2..16).
REQ-005 SHALL have parameter LAT_VEC, default {4'd7,4'd4,4'd1,4'd1}, packed 4-bit latency per channel (ch0 in LSBs); each value SHALL be in 1..DEPTH.
REQ-006 clk  input  1  single clock, rising edge.
REQ-007 reset  input  1  asynchronous, active-high.
REQ-008 req  input  N_CH  channel c has an instruction ready to issue.
REQ-009 busy  input  N_CH  channel c cannot accept (non-pipelined unit occupied).
REQ-010 unit_data  input  N_CH*DATA_W  per-channel result bus, ch0 in LSBs.
REQ-011 unit_tag  input  N_CH*TAG_W  per-channel result tag.
REQ-012 grant  output  N_CH  one-hot issue grant, combinational, same cycle as req.
REQ-013 grant_valid  output  1  OR of grant.
REQ-014 cdb_valid  output  1  CDB carries a result this cycle.
REQ-015 cdb_sel  output  N_CH  one-hot owner of the CDB this cycle.
REQ-016 cdb_data  output  DATA_W  result selected from unit_data by cdb_sel.
REQ-017 cdb_tag  output  TAG_W  tag selected from unit_tag by cdb_sel.
REQ-018 stall_cnt  output  16  saturating count of stalled cycles.

Function
REQ-019 SHALL hold a reservation vector res[0..DEPTH-1] and owner registers own[0..DEPTH-1]; res[k]=1 means CDB occupied k cycles from now.
REQ-020 Each cycle res/own SHALL shift down one slot; res[DEPTH-1] fills with 0.
REQ-021 Channel c SHALL be eligible iff req[c] & ~busy[c] & ~res[L_c].
REQ-022 At most one grant per cycle (single dispatch port); grant SHALL be 0 when no channel is eligible.
REQ-023 Grant of c in cycle t SHALL set res[L_c-1] and own[L_c-1]=c in the post-shift state, so the CDB is driven at cycle t+L_c.
REQ-024 cdb_valid SHALL equal res[0]; cdb_sel SHALL be onehot(own[0]) when res[0]=1, else 0.
REQ-025 cdb_data/cdb_tag SHALL be the owner's unit_data/unit_tag when cdb_valid=1, else all zeros.
REQ-026 At most one result SHALL occupy the CDB per cycle; two grants SHALL never map to one slot.
REQ-027 stall_cnt SHALL increment when |req and grant_valid=0, or when more than one channel is eligible; SHALL saturate at 16'hFFFF.
REQ-028 Requests and grants SHALL not be latched; an ungranted req SHALL be re-evaluated next cycle.
REQ-029 A latency-1 grant SHALL be issuable in a cycle where res[0]=1 (slot 1 checked, not slot 0).

Reset
REQ-030 reset SHALL asynchronously clear res, own, round-robin pointer and stall_cnt.
REQ-031 During reset grant, grant_valid, cdb_valid, cdb_sel, cdb_data, cdb_tag SHALL be 0.
REQ-032 Reset mid-operation SHALL discard all pending reservations; no result SHALL appear on CDB after deassertion until a new grant.

Configuration
REQ-033 Macro CDB_SCHED_RR_ARB_EN defined: among eligible channels SHALL grant the first at or after pointer rr; after a grant to c, rr SHALL become (c+1) mod N_CH.
REQ-034 Macro undefined: SHALL grant the lowest-index eligible channel; no pointer register exists.

Verification
REQ-035 req=4'b0001 at t0 (L=1), unit_data[0]=32'hA5A5A5A5, unit_tag[0]=6'd9 -> grant=0001 at t0; t0+1 cdb_valid=1, cdb_sel=0001, cdb_data=A5A5A5A5, cdb_tag=9.
REQ-036 req=4'b1000 at t0 (L=7), then req=4'b0001 at t0+6 -> ch0 stalled at t0+6, stall_cnt=1; granted at t0+7; CDB owners ch3 at t0+7, ch0 at t0+8.
REQ-037 req=4'b0011 held 4 cycles, RR_ARB_EN defined -> grants 0001,0010,0001,0010; undefined -> 0001 all four cycles, stall_cnt=4.
REQ-038 req=4'b0100 at t0 (L=4), reset pulsed at t0+2 -> cdb_valid stays 0 through t0+6, stall_cnt=0.
REQ-039 busy[3]=1 with req[3]=1 for 20 cycles -> no grant, stall_cnt=20; force stall_cnt near FFFF -> holds at 16'hFFFF.

Source files
------------

// File: rtl/cdb_sched.sv
// Issue scheduler for a shared common data bus: reserves the CDB slot each grant will occupy.
// Optional round-robin arbitration is enabled by defining CDB_SCHED_RR_ARB_EN.
module cdb_sched #(
    parameter int N_CH   = 4,
    parameter int DATA_W = 32,
    parameter int TAG_W  = 6,
    parameter int DEPTH  = 8,
    parameter logic [4*N_CH-1:0] LAT_VEC = {4'd7, 4'd4, 4'd1, 4'd1}
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [N_CH-1:0]          req,
    input  logic [N_CH-1:0]          busy,
    input  logic [N_CH*DATA_W-1:0]   unit_data,
    input  logic [N_CH*TAG_W-1:0]    unit_tag,
    output logic [N_CH-1:0]          grant,
    output logic                     grant_valid,
    output logic                     cdb_valid,
    output logic [N_CH-1:0]          cdb_sel,
    output logic [DATA_W-1:0]        cdb_data,
    output logic [TAG_W-1:0]         cdb_tag,
    output logic [15:0]              stall_cnt
);

    localparam int PTR_W = (N_CH > 1) ? $clog2(N_CH) : 1;

    logic [DEPTH-1:0] res_q, res_d;
    logic [PTR_W-1:0] own_q [DEPTH];
    logic [PTR_W-1:0] own_d [DEPTH];
    logic [15:0]      stall_q, stall_d;
    logic [N_CH-1:0]  elig;
    logic [N_CH-1:0]  grant_raw;
    logic [DEPTH-1:0] slot_mask [N_CH];
    logic             multi_elig;

    // A grant lands in post-shift slot L-1, so the pre-shift slot L must be free.
    for (genvar c = 0; c < N_CH; c++) begin : g_ch
        localparam int L = int'(LAT_VEC[4*c +: 4]);
        if (L < DEPTH) begin : g_chk
            assign elig[c] = req[c] & ~busy[c] & ~res_q[L];
        end else begin : g_top
            assign elig[c] = req[c] & ~busy[c];
        end
        assign slot_mask[c] = DEPTH'(1) << (L - 1);
    end

    assign multi_elig = (elig & (elig - 1'b1)) != '0;

`ifdef CDB_SCHED_RR_ARB_EN
    logic [PTR_W-1:0] rr_q, rr_d;
    logic [PTR_W-1:0] gidx;
    logic             found;

    // First pass takes channels at/after the pointer, second pass wraps around.
    always_comb begin
        grant_raw = '0;
        gidx      = '0;
        found     = 1'b0;
        for (int c = 0; c < N_CH; c++) begin
            if (!found && elig[c] && (PTR_W'(c) >= rr_q)) begin
                grant_raw[c] = 1'b1;
                gidx         = PTR_W'(c);
                found        = 1'b1;
            end
        end
        for (int c = 0; c < N_CH; c++) begin
            if (!found && elig[c]) begin
                grant_raw[c] = 1'b1;
                gidx         = PTR_W'(c);
                found        = 1'b1;
            end
        end
        rr_d = rr_q;
        if (found) begin
            rr_d = (gidx == PTR_W'(N_CH - 1)) ? '0 : gidx + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rr_q <= '0;
        end else begin
            rr_q <= rr_d;
        end
    end
`else
    logic found;

    always_comb begin
        grant_raw = '0;
        found     = 1'b0;
        for (int c = 0; c < N_CH; c++) begin
            if (!found && elig[c]) begin
                grant_raw[c] = 1'b1;
                found        = 1'b1;
            end
        end
    end
`endif

    assign grant       = reset ? '0 : grant_raw;
    assign grant_valid = |grant;

    always_comb begin
        res_d = {1'b0, res_q[DEPTH-1:1]};
        for (int k = 0; k < DEPTH - 1; k++) begin
            own_d[k] = own_q[k+1];
        end
        own_d[DEPTH-1] = '0;
        for (int c = 0; c < N_CH; c++) begin
            if (grant_raw[c]) begin
                res_d = res_d | slot_mask[c];
                for (int k = 0; k < DEPTH; k++) begin
                    if (slot_mask[c][k]) begin
                        own_d[k] = PTR_W'(c);
                    end
                end
            end
        end
        stall_d = stall_q;
        if ((((|req) && !(|grant_raw)) || multi_elig) && (stall_q != 16'hFFFF)) begin
            stall_d = stall_q + 16'd1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            res_q   <= '0;
            stall_q <= '0;
            for (int k = 0; k < DEPTH; k++) begin
                own_q[k] <= '0;
            end
        end else begin
            res_q   <= res_d;
            stall_q <= stall_d;
            for (int k = 0; k < DEPTH; k++) begin
                own_q[k] <= own_d[k];
            end
        end
    end

    assign cdb_valid = res_q[0];
    assign stall_cnt = stall_q;

    always_comb begin
        cdb_sel  = '0;
        cdb_data = '0;
        cdb_tag  = '0;
        for (int c = 0; c < N_CH; c++) begin
            if (res_q[0] && (own_q[0] == PTR_W'(c))) begin
                cdb_sel[c] = 1'b1;
                cdb_data   = unit_data[c*DATA_W +: DATA_W];
                cdb_tag    = unit_tag[c*TAG_W +: TAG_W];
            end
        end
    end

endmodule

// File: tb/tb_cdb_sched.sv
// Bench for cdb_sched: grant vector table, CDB scoreboard, and multi-cycle corner sequences.
module tb_cdb_sched;
    localparam int N_CH   = 4;
    localparam int DATA_W = 32;
    localparam int TAG_W  = 6;
    localparam int DEPTH  = 8;

    logic                   clk = 1'b0;
    logic                   reset;
    logic [N_CH-1:0]        req;
    logic [N_CH-1:0]        busy;
    logic [N_CH*DATA_W-1:0] unit_data;
    logic [N_CH*TAG_W-1:0]  unit_tag;
    logic [N_CH-1:0]        grant;
    logic                   grant_valid;
    logic                   cdb_valid;
    logic [N_CH-1:0]        cdb_sel;
    logic [DATA_W-1:0]      cdb_data;
    logic [TAG_W-1:0]       cdb_tag;
    logic [15:0]            stall_cnt;

    cdb_sched #(.N_CH(N_CH), .DATA_W(DATA_W), .TAG_W(TAG_W), .DEPTH(DEPTH)) dut (
        .clk(clk), .reset(reset), .req(req), .busy(busy),
        .unit_data(unit_data), .unit_tag(unit_tag),
        .grant(grant), .grant_valid(grant_valid),
        .cdb_valid(cdb_valid), .cdb_sel(cdb_sel), .cdb_data(cdb_data),
        .cdb_tag(cdb_tag), .stall_cnt(stall_cnt)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int total = 0;
    int bad   = 0;
    int lat_tab [N_CH] = '{1, 1, 4, 7};

    // scoreboard: expected {sel, tag, data} and the cycle it must appear
    logic [N_CH+TAG_W+DATA_W-1:0] exp_q [$];
    int                           due_q [$];

    typedef struct {
        logic [3:0] req;
        logic [3:0] busy;
        logic [3:0] exp_grant;
        int         exp_ch;
        logic [15:0] exp_stall;
    } vec_t;

    vec_t vecs [8];

    function automatic logic [31:0] ch_data(int c);
        return 32'hA5A5A5A5 ^ (32'(c) * 32'h01010101);
    endfunction

    function automatic logic [5:0] ch_tag(int c);
        return 6'(9 + c);
    endfunction

    task automatic check(string name, logic [63:0] act, logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic expect_cdb(int c);
        logic [N_CH-1:0] sel;
        sel = 4'b0001 << c;
        exp_q.push_back({sel, ch_tag(c), ch_data(c)});
        due_q.push_back(cyc + lat_tab[c]);
    endtask

    task automatic do_reset();
        step();
        reset = 1'b1;
        req   = 4'b1111;
        busy  = 4'b0000;
        exp_q.delete();
        due_q.delete();
        #1;
        check("rst_grant", 64'(grant), 64'd0);
        check("rst_grant_valid", 64'(grant_valid), 64'd0);
        check("rst_cdb", 64'({cdb_valid, cdb_sel, cdb_tag, cdb_data}), 64'd0);
        check("rst_stall", 64'(stall_cnt), 64'd0);
        step();
        reset = 1'b0;
        req   = 4'b0000;
    endtask

    // CDB monitor: every result must arrive exactly on its due cycle
    initial begin
        forever begin
            @(negedge clk);
            if (!reset) begin
                if (due_q.size() > 0 && due_q[0] == cyc) begin
                    void'(due_q.pop_front());
                    check("cdb_valid", 64'(cdb_valid), 64'd1);
                    check("cdb_out", 64'({cdb_sel, cdb_tag, cdb_data}), 64'(exp_q.pop_front()));
                end else if (cdb_valid) begin
                    total++;
                    bad++;
                    $display("FAIL cdb_unexpected: got sel=%0h expected no result (cycle %0d)", cdb_sel, cyc);
                end
            end
        end
    end

    initial begin
        logic [3:0] exp_g;
        int         exp_c;
        reset = 1'b1;
        req   = '0;
        busy  = '0;
        for (int c = 0; c < N_CH; c++) begin
            unit_data[c*DATA_W +: DATA_W] = ch_data(c);
            unit_tag[c*TAG_W +: TAG_W]    = ch_tag(c);
        end

        vecs[0] = '{4'b0001, 4'b0000, 4'b0001,  0, 16'd0};
        vecs[1] = '{4'b0110, 4'b0000, 4'b0010,  1, 16'd1};
        vecs[2] = '{4'b1100, 4'b0100, 4'b1000,  3, 16'd0};
        vecs[3] = '{4'b1111, 4'b1111, 4'b0000, -1, 16'd1};
        vecs[4] = '{4'b0000, 4'b0000, 4'b0000, -1, 16'd0};
        vecs[5] = '{4'b1010, 4'b0010, 4'b1000,  3, 16'd0};
        vecs[6] = '{4'b0100, 4'b0000, 4'b0100,  2, 16'd0};
        vecs[7] = '{4'b1111, 4'b0001, 4'b0010,  1, 16'd1};

        repeat (2) @(posedge clk);

        // single-cycle vectors from a clean reservation state
        for (int i = 0; i < 8; i++) begin
            do_reset();
            req  = vecs[i].req;
            busy = vecs[i].busy;
            #1;
            check("vec_grant", 64'(grant), 64'(vecs[i].exp_grant));
            check("vec_grant_valid", 64'(grant_valid), 64'(vecs[i].exp_grant != 0));
            if (vecs[i].exp_ch >= 0) expect_cdb(vecs[i].exp_ch);
            step();
            req  = '0;
            busy = '0;
            check("vec_stall", 64'(stall_cnt), 64'(vecs[i].exp_stall));
            repeat (8) step();
        end

        // ch3 (L=7) reserves t0+7; ch0 (L=1) blocked at t0+6, issues at t0+7 while slot 0 busy
        do_reset();
        req = 4'b1000;
        #1;
        check("seqb_grant_t0", 64'(grant), 64'b1000);
        expect_cdb(3);
        for (int k = 0; k < 5; k++) begin
            step();
            req = '0;
        end
        step();
        req = 4'b0001;
        #1;
        check("seqb_grant_t6", 64'(grant), 64'd0);
        step();
        check("seqb_stall", 64'(stall_cnt), 64'd1);
        check("seqb_grant_t7", 64'(grant), 64'b0001);
        expect_cdb(0);
        step();
        req = '0;
        repeat (8) step();

        // two latency-1 channels contending for four cycles
        do_reset();
        for (int k = 0; k < 4; k++) begin
            req = 4'b0011;
            #1;
`ifdef CDB_SCHED_RR_ARB_EN
            exp_c = k % 2;
`else
            exp_c = 0;
`endif
            exp_g = 4'b0001 << exp_c;
            check("seqc_grant", 64'(grant), 64'(exp_g));
            expect_cdb(exp_c);
            step();
        end
        req = '0;
        check("seqc_stall", 64'(stall_cnt), 64'd4);
        repeat (8) step();

        // reset mid-flight discards the ch2 reservation
        do_reset();
        req = 4'b0100;
        #1;
        check("seqd_grant", 64'(grant), 64'b0100);
        step();
        req = '0;
        step();
        reset = 1'b1;
        #1;
        check("seqd_cdb_in_rst", 64'(cdb_valid), 64'd0);
        step();
        reset = 1'b0;
        for (int k = 0; k < 4; k++) begin
            #1;
            check("seqd_cdb_quiet", 64'(cdb_valid), 64'd0);
            step();
        end
        check("seqd_stall", 64'(stall_cnt), 64'd0);

        // busy channel never granted; stall counter saturates
        do_reset();
        req  = 4'b1000;
        busy = 4'b1000;
        for (int k = 0; k < 20; k++) begin
            #1;
            check("seqe_grant", 64'(grant), 64'd0);
            step();
        end
        check("seqe_stall20", 64'(stall_cnt), 64'd20);
        repeat (65520) step();
        check("seqe_stall_sat", 64'(stall_cnt), 64'hFFFF);
        step();
        check("seqe_stall_hold", 64'(stall_cnt), 64'hFFFF);
        req  = '0;
        busy = '0;

        repeat (10) step();
        check("sb_empty", 64'(due_q.size()), 64'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
